// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM status codes and the arbiter state encoding.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one RAM port between the icache and dcache: dcache has priority, but a
// bounded run of data grants with an instruction fetch pending forces an icache grant.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W       = CPU_WORD_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              bus_err,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t        state_reg, state_next;
    logic [3:0]        starve_cnt_reg, starve_cnt_next;
    logic [WORD_W-1:0] iload_reg, dload_reg;

    ramstate_t rs;
    logic      d_req;
    logic      starved;
    logic      grant_live;
    logic      done;
    logic      err;

    assign rs      = ramstate_t'(ramstate);
    assign d_req   = dREN | dWEN;
    assign starved = iREN && (starve_cnt_reg == LIMIT);

    // A grant is only live while its requester keeps asking; withdrawal cancels it.
    always_comb begin
        grant_live = 1'b0;
        case (state_reg)
            DGRANT:  grant_live = d_req;
            IGRANT:  grant_live = iREN;
            default: grant_live = 1'b0;
        endcase
    end

    assign done = grant_live && (rs == ACCESS);
    assign err  = grant_live && (rs == ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_reg <= '0;
            iload_reg      <= '0;
            dload_reg      <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            if (done && state_reg == IGRANT) begin
                iload_reg <= ramload;
            end
            if (done && state_reg == DGRANT) begin
                dload_reg <= ramload;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (!iREN) begin
                    starve_cnt_next = '0;
                end
                if (d_req && !starved) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end
            DGRANT: begin
                if (!grant_live || err || done) begin
                    state_next = IDLE;
                end
                if (done && iREN && starve_cnt_reg != LIMIT) begin
                    starve_cnt_next = starve_cnt_reg + 4'd1;
                end
            end
            IGRANT: begin
                if (!grant_live || err || done) begin
                    state_next = IDLE;
                end
                if (done) begin
                    starve_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load outputs pass ramload through in the completion cycle so the cache sees it with wait low.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = iload_reg;
        dload    = dload_reg;
        bus_err  = err;
        case (state_reg)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                if (done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the cache block (icache + dcache).
- Arbitrates the instruction-fetch and data request channels onto the single shared RAM port.
- Registered-grant FSM with dcache priority, plus a starvation counter that forces an icache grant after a bounded run of data grants.
- Returns per-channel wait, load data and an error pulse to the caches.

Parameters:
WORD_W, 32, width of addresses, store data and load data
STARVE_LIMIT, 4, consecutive D grants taken while iREN is pending before an I grant is forced (range 1..15)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  icache read request
iaddr  in  WORD_W  icache word address
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  WORD_W  dcache word address
dstore  in  WORD_W  dcache write data
iwait  out  1  low for exactly the icache completion cycle
dwait  out  1  low for exactly the dcache completion cycle
iload  out  WORD_W  instruction read data, valid when iwait is low
dload  out  WORD_W  data read data, valid when dwait is low
bus_err  out  1  one-cycle pulse when RAM returns ERROR
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, starve_cnt=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0, bus_err=0.
- States: IDLE, DGRANT, IGRANT.
- RAM-side outputs are combinational from state and the granted channel's inputs; in IDLE all RAM enables are 0.
- IDLE transitions:
  - (dREN|dWEN) and not starved -> DGRANT.
  - Else iREN -> IGRANT.
  - Else stay.
  - starved := iREN && starve_cnt==STARVE_LIMIT.
- DGRANT drive:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN, ramWEN=1 and ramREN=0; else ramREN=dREN.
  - dWEN wins if both dREN and dWEN are high.
- IGRANT drive: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion: in a grant state with ramstate==ACCESS:
  - The granted wait goes low that same cycle, and the load output is driven from ramload.
  - Next state is IDLE.
- Wait rule: the non-granted wait stays 1 in every cycle.
- Latency: a request seen in IDLE at cycle N drives the RAM from cycle N+1.
  - With a zero-latency RAM, wait drops in cycle N+1.
  - Minimum spacing between two grants is 2 cycles, because IDLE is always revisited.
- BUSY or FREE while granted: hold the state, keep the enables asserted, keep the wait high.
- ERROR while granted:
  - bus_err=1 for that cycle, the wait stays high, next state is IDLE.
  - The requester retries automatically while its enable is held; the retry is a new arbitration.
- Request withdrawn mid-grant (granted channel's REN/WEN all low): RAM enables drop the same cycle, next state is IDLE, no completion, starve_cnt unchanged.
- Starvation counter:
  - On each DGRANT completion with iREN high: starve_cnt saturating-increments up to STARVE_LIMIT.
  - On IGRANT completion, or iREN low in IDLE: starve_cnt := 0.
- Address or data changes mid-grant pass through; holding them stable is the requester's responsibility.
- nRST asserted mid-grant: all outputs return to reset values immediately (asynchronous); no completion is reported.
- iload/dload hold their last driven value outside their completion cycle; the caches sample only when wait is low.

Decomposition:
- cpu_types_pkg holds word_t (WORD_W bits), ramstate_t (FREE, BUSY, ACCESS, ERROR) and the new arb_state_t (IDLE, DGRANT, IGRANT).
- Single module, no sub-module: the FSM plus the small saturating counter fit comfortably under 200 lines.
- The caches wrapper's cif signals connect port-for-port at the top level.

Test Plan:
- Reset: nRST=0 with random inputs -> iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0, bus_err=0; still holds after nRST release with no requests.
- I fetch: iREN=1, iaddr=0x100, RAM latency 2 cycles (BUSY,BUSY,ACCESS), ramload=0xDEADBEEF.
  - Expected: ramREN=1, ramaddr=0x100 from cycle 1; iwait low only in cycle 3 with iload=0xDEADBEEF; dwait=1 throughout.
- Simultaneous: iREN=1, dWEN=1, daddr=0x200, dstore=0x12345678, zero-latency RAM.
  - Expected: DGRANT first, ramWEN=1, ramaddr=0x200, dwait low; next IGRANT after one IDLE cycle.
- Starvation: dREN and iREN held high, STARVE_LIMIT=4, zero-latency RAM -> exactly 4 D completions, then one I completion, then D resumes.
- ERROR: dREN=1, ramstate=ERROR in the first grant cycle -> bus_err pulses once, dwait stays 1, FSM re-grants D, and ACCESS then completes normally.
- Withdraw / reset mid-grant: drop dREN during BUSY -> ramREN=0 that cycle and state IDLE; separately, assert nRST during BUSY -> outputs reach reset values without waiting for a clock edge.
